// File: rtl/lut_activation_pkg.sv
// Shared definitions for the LUT activation pipeline: controller states and
// the fixed input-to-output latency.
package lut_activation_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } lut_state_t;

  localparam int PIPE_LATENCY = 2;

endpackage

// File: rtl/lut_activation_ram.sv
// One lane's copy of the activation table: one write port and one registered
// read port that returns the old contents when both hit the same address.
module lut_activation_ram
  import lut_activation_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  // The table itself is never cleared; it survives reset and must be reloaded.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fixed_lut_activation_pipe.sv
// Two-stage fixed-point activation: each lane looks its input up in a
// programmable table, or passes it through resized when bypass is set.
module fixed_lut_activation_pipe
  import lut_activation_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0       = 8,
  parameter int DATA_IN_0_PRECISION_1       = 4,
  parameter int DATA_OUT_0_PRECISION_0      = 8,
  parameter int DATA_OUT_0_PRECISION_1      = 4,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
  input  logic                              data_in_0_valid,
  output logic                              data_in_0_ready,
  output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
  output logic                              data_out_0_valid,
  input  logic                              data_out_0_ready,
  input  logic                              lut_wr_valid,
  output logic                              lut_wr_ready,
  input  logic [DATA_IN_0_PRECISION_0-1:0]  lut_wr_addr,
  input  logic [DATA_OUT_0_PRECISION_0-1:0] lut_wr_data,
  input  logic                              lut_wr_last,
  input  logic                              bypass,
  output logic                              lut_loaded
);

  localparam int  P        = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
  localparam int  IN_W     = DATA_IN_0_PRECISION_0;
  localparam int  OUT_W    = DATA_OUT_0_PRECISION_0;
  localparam bit  IDENT_OK = (DATA_IN_0_PRECISION_1 == DATA_OUT_0_PRECISION_1);

  logic [1:0] rst_sync;
  logic       rst_n;

  lut_state_t state;
  lut_state_t state_next;

  logic            s1_valid;
  logic            s1_bypass;
  logic [IN_W-1:0] s1_data [P];
  logic            s2_valid;
  logic            s2_bypass;

  logic bypass_eff;
  logic advance;
  logic in_ready;
  logic wr_ready;
  logic in_hs;
  logic wr_hs;

  // Reset asserts immediately but is released only on a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  // Identity mode only makes sense when both binary points line up.
  assign bypass_eff = bypass && IDENT_OK;
  assign advance    = !s2_valid || data_out_0_ready;
  assign in_hs      = data_in_0_valid && in_ready;
  assign wr_hs      = lut_wr_valid && wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    wr_ready   = 1'b0;
    in_ready   = 1'b0;
    if (rst_n) begin
      unique case (state)
        EMPTY, LOAD: begin
          wr_ready = 1'b1;
          in_ready = bypass_eff && advance;
        end
        READY: begin
          wr_ready = !s1_valid && !s2_valid;
          in_ready = !lut_wr_valid && advance;
        end
        default: begin
          wr_ready = 1'b0;
          in_ready = 1'b0;
        end
      endcase
      if (lut_wr_valid && wr_ready) begin
        state_next = lut_wr_last ? READY : LOAD;
      end
    end
  end

  assign data_in_0_ready  = in_ready;
  assign lut_wr_ready     = wr_ready;
  assign lut_loaded       = (state == READY);
  assign data_out_0_valid = s2_valid;

  // Both stages move together; a stalled output freezes the whole pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_bypass <= 1'b0;
      s2_valid  <= 1'b0;
      s2_bypass <= 1'b0;
      for (int i = 0; i < P; i++) begin
        s1_data[i] <= '0;
      end
    end else if (advance) begin
      s1_valid  <= in_hs;
      s2_valid  <= s1_valid;
      s2_bypass <= s1_bypass;
      if (in_hs) begin
        s1_bypass <= bypass_eff;
        for (int i = 0; i < P; i++) begin
          s1_data[i] <= data_in_0[i];
        end
      end
    end
  end

  for (genvar i = 0; i < P; i++) begin : g_lane
    logic [OUT_W-1:0] lut_q;
    logic [OUT_W-1:0] ident_q;

    // The raw input bits address the table, so negative words use the upper half.
    lut_activation_ram #(
      .ADDR_W(IN_W),
      .DATA_W(OUT_W)
    ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_hs),
      .wr_addr (lut_wr_addr),
      .wr_data (lut_wr_data),
      .rd_en   (advance),
      .rd_addr (s1_data[i]),
      .rd_data (lut_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ident_q <= '0;
      end else if (advance) begin
        ident_q <= OUT_W'(signed'(s1_data[i]));
      end
    end

    assign data_out_0[i] = s2_bypass ? ident_q : lut_q;
  end

endmodule
